// File: rtl/akarin_boot_pkg.sv
// Shared definitions for the framed byte-stream boot loader.
package akarin_boot_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } boot_state_t;

  // 8-bit wrapping checksum accumulation.
  function automatic logic [7:0] boot_sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/mbus_boot_loader_if.sv
// Byte-stream input and memory-bus write side of the boot loader.
interface mbus_boot_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_valid, rx_byte,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_byte,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mbus_boot_loader.sv
// Boot loader: parses SYNC/LEN/DATA/CSUM frames, writes words to instruction
// memory and holds the core in reset until the checksum verifies.
module mbus_boot_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DEPTH     = 4096,
  parameter logic [7:0]  SYNC_BYTE = akarin_boot_pkg::SYNC_BYTE
) (
  input  logic               clk,
  input  logic               rst,
  mbus_boot_loader_if.master bus,
  output logic               core_rst,
  output logic               done,
  output logic               error
);
  import akarin_boot_pkg::*;

  boot_state_t       state, state_nxt;
  logic              rx_ready_q;
  logic [1:0]        bcnt;
  logic [31:0]       len_q;
  logic [31:0]       len_shift;
  logic [31:0]       wbuf;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W:0]   widx_p1;
  logic              rx_fire;
  logic              last_word;

  assign rx_fire   = bus.rx_valid && rx_ready_q;
  assign len_shift = {bus.rx_byte, len_q[31:8]};
  // One extra bit so the final index compare works when LEN == 2**ADDR_W.
  assign widx_p1   = {1'b0, widx} + (ADDR_W+1)'(1);
  assign last_word = (widx_p1 == len_q[ADDR_W:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SYNC;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SYNC:  if (rx_fire && bus.rx_byte == SYNC_BYTE) state_nxt = LEN;
      LEN:   if (rx_fire && bcnt == 2'd3) begin
               if (len_shift > 32'(DEPTH))  state_nxt = ERR;
               else if (len_shift == 32'd0) state_nxt = CSUM;
               else                         state_nxt = DATA;
             end
      DATA:  if (rx_fire && bcnt == 2'd3) state_nxt = WRITE;
      WRITE: state_nxt = last_word ? CSUM : DATA;
      CSUM:  if (rx_fire) state_nxt = (boot_sum8(sum, bus.rx_byte) == 8'h00) ? DONE : ERR;
      DONE:  state_nxt = DONE;
      ERR:   state_nxt = ERR;
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready_q <= 1'b0;
      bcnt       <= '0;
      len_q      <= '0;
      wbuf       <= '0;
      sum        <= '0;
      widx       <= '0;
    end else begin
      // Registered ready follows the state being entered, so WRITE/DONE/ERR
      // never see an accepted byte.
      rx_ready_q <= (state_nxt inside {SYNC, LEN, DATA, CSUM});
      unique case (state)
        SYNC: begin
          sum  <= '0;
          bcnt <= '0;
          widx <= '0;
        end
        LEN: if (rx_fire) begin
          len_q <= len_shift;
          bcnt  <= bcnt + 2'd1;
        end
        DATA: if (rx_fire) begin
          wbuf <= {bus.rx_byte, wbuf[31:8]};
          sum  <= boot_sum8(sum, bus.rx_byte);
          bcnt <= bcnt + 2'd1;
        end
        WRITE: if (!last_word) widx <= widx + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = widx;
  assign bus.mem_wdata = wbuf;
  assign core_rst      = (state == DONE);
  assign done          = (state == DONE);
  assign error         = (state == ERR);

endmodule

// File: tb/tb_mbus_boot_loader.sv
// Randomized frame-level bench for mbus_boot_loader with a frame-parsing reference model.
module tb_mbus_boot_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic core_rst, done, error;

  mbus_boot_loader_if #(.ADDR_W(12)) bus ();

  mbus_boot_loader #(.ADDR_W(12), .DEPTH(4096), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .core_rst(core_rst), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int unsigned cyc = 0;
  int rdy_viol = 0;

  logic [7:0]  stim[$];
  logic [31:0] words[$];
  int unsigned acc_cyc[$];
  logic [11:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int unsigned wr_cyc[$];
  logic [31:0] exp_data[$];
  int          exp_outcome;   // 0 loading, 1 done, 2 error
  int          exp_off;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      wr_cyc.push_back(cyc);
      if (bus.rx_ready) rdy_viol++;
    end
  end

  // ---------------- stimulus construction ----------------
  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
  endtask

  task automatic push_frame(input logic [31:0] len, input logic [7:0] delta);
    logic [7:0] s;
    s = 8'h00;
    stim.push_back(8'hA5);
    push_word(len);
    if (len <= 32'd4096) begin
      for (int w = 0; w < int'(len); w++) begin
        push_word(words[w]);
        for (int k = 0; k < 4; k++) s = s + words[w][8*k +: 8];
      end
      stim.push_back(8'(8'h00 - s + delta));
    end
  endtask

  // Reference: parse the stream per the frame rules with plain arithmetic.
  task automatic model_frame();
    int i;
    int sum;
    logic [31:0] len;
    exp_data.delete();
    exp_outcome = 0;
    exp_off = 0;
    i = 0;
    while (i < stim.size() && stim[i] != 8'hA5) i++;
    i++;
    len = {stim[i+3], stim[i+2], stim[i+1], stim[i]};
    i += 4;
    if (len > 32'd4096) begin exp_outcome = 2; return; end
    exp_off = i;
    sum = 0;
    for (int w = 0; w < int'(len); w++) begin
      exp_data.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
      sum += int'(stim[i]) + int'(stim[i+1]) + int'(stim[i+2]) + int'(stim[i+3]);
      i += 4;
    end
    sum += int'(stim[i]);
    exp_outcome = (sum % 256 == 0) ? 1 : 2;
  endtask

  task automatic send_stream(input int gap_pct, input string name);
    int n;
    acc_cyc.delete();
    foreach (stim[j]) begin
      for (int g = 0; g < 6 && int'($urandom_range(99)) < gap_pct; g++) begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'($urandom);
        @(negedge clk);
      end
      bus.rx_valid = 1'b1;
      bus.rx_byte  = stim[j];
      n = 0;
      while (!bus.rx_ready && n < 40) begin @(negedge clk); n++; end
      if (!bus.rx_ready) begin
        checks++;
        $display("FAIL %s byte %0d not accepted: rx_ready=%b required 1", name, j, bus.rx_ready);
        bus.rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
      acc_cyc.push_back(cyc);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rst = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [3:0] flags_for(input int outcome);
    return (outcome == 1) ? 4'b1010 : (outcome == 2) ? 4'b0100 : 4'b0001;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_rst, done, error} !== '0)
      $display("FAIL reset_outputs rdy=%b we=%b addr=%h wdata=%h core_rst=%b done=%b error=%b required all 0",
               bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_rst, done, error);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0) $display("FAIL reset_first_cycle rx_ready=%b required 0", bus.rx_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if ({bus.rx_ready, core_rst, done, error} !== 4'b1000)
      $display("FAIL reset_second_cycle rdy/core_rst/done/error=%b required 1000", {bus.rx_ready, core_rst, done, error});
    else passes++;
  endtask

  task automatic test_frame_table();
    string name;
    for (int t = 0; t < 5; t++) begin
      do_reset();
      stim.delete();
      words.delete();
      words.push_back(32'h0000_0013);
      words.push_back(32'h0010_0093);
      case (t)
        0: begin name = "nominal";  push_frame(32'd2, 8'h00); end
        1: begin name = "garbage";  stim.push_back(8'h00); stim.push_back(8'hFF); stim.push_back(8'h5A);
                 push_frame(32'd2, 8'h00); end
        2: begin name = "bad_csum"; push_frame(32'd2, 8'h01); end
        3: begin name = "oversize"; push_frame(32'h0000_1001, 8'h00); end
        default: begin name = "len_zero"; push_frame(32'd0, 8'h00); end
      endcase
      model_frame();
      send_stream(0, name);
      checks++;
      if ({done, error, core_rst, bus.rx_ready} !== flags_for(exp_outcome))
        $display("FAIL %s outcome done/error/core_rst/rdy=%b required %b", name,
                 {done, error, core_rst, bus.rx_ready}, flags_for(exp_outcome));
      else passes++;
      checks++;
      if (wr_data.size() != exp_data.size())
        $display("FAIL %s write_count got %0d required %0d", name, wr_data.size(), exp_data.size());
      else passes++;
      for (int k = 0; k < wr_data.size() && k < exp_data.size(); k++) begin
        logic on_time;
        on_time = (exp_off + 4*k + 3 < acc_cyc.size()) && (wr_cyc[k] == acc_cyc[exp_off + 4*k + 3]);
        checks++;
        if (wr_addr[k] !== 12'(k) || wr_data[k] !== exp_data[k] || !on_time)
          $display("FAIL %s write%0d addr=%h data=%h on_time=%b required addr=%h data=%h on_time=1",
                   name, k, wr_addr[k], wr_data[k], on_time, 12'(k), exp_data[k]);
        else passes++;
      end
      if (t < 3 && wr_data.size() == 2) begin
        checks++;
        if (wr_data[0] !== 32'h0000_0013 || wr_data[1] !== 32'h0010_0093)
          $display("FAIL %s words got %h %h required 00000013 00100093", name, wr_data[0], wr_data[1]);
        else passes++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({done, error, core_rst, bus.rx_ready, bus.mem_we} !== {flags_for(exp_outcome), 1'b0})
        $display("FAIL %s sticky done/error/core_rst/rdy/we=%b required %b", name,
                 {done, error, core_rst, bus.rx_ready, bus.mem_we}, {flags_for(exp_outcome), 1'b0});
      else passes++;
    end
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 8; it++) begin
      int len;
      do_reset();
      stim.delete();
      words.delete();
      len = int'($urandom_range(1, 12));
      for (int g = int'($urandom_range(3)); g > 0; g--) stim.push_back(8'($urandom_range(0, 8'hA4)));
      for (int w = 0; w < len; w++) words.push_back($urandom);
      push_frame(32'(len), ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      model_frame();
      send_stream(45, "random_gaps");
      checks++;
      if ({done, error, core_rst, bus.rx_ready} !== flags_for(exp_outcome))
        $display("FAIL random_gaps it%0d outcome=%b required %b", it,
                 {done, error, core_rst, bus.rx_ready}, flags_for(exp_outcome));
      else passes++;
      checks++;
      if (wr_data.size() != exp_data.size())
        $display("FAIL random_gaps it%0d write_count got %0d required %0d", it, wr_data.size(), exp_data.size());
      else passes++;
      for (int k = 0; k < wr_data.size() && k < exp_data.size(); k++) begin
        logic on_time;
        on_time = (exp_off + 4*k + 3 < acc_cyc.size()) && (wr_cyc[k] == acc_cyc[exp_off + 4*k + 3]);
        checks++;
        if (wr_addr[k] !== 12'(k) || wr_data[k] !== exp_data[k] || !on_time)
          $display("FAIL random_gaps it%0d write%0d addr=%h data=%h on_time=%b required addr=%h data=%h on_time=1",
                   it, k, wr_addr[k], wr_data[k], on_time, 12'(k), exp_data[k]);
        else passes++;
      end
    end
    checks++;
    if (rdy_viol != 0) $display("FAIL ready_during_write count=%0d required 0", rdy_viol);
    else passes++;
  endtask

  task automatic test_len_max();
    int bad;
    do_reset();
    stim.delete();
    words.delete();
    for (int w = 0; w < 4096; w++) words.push_back($urandom);
    push_frame(32'd4096, 8'h00);
    model_frame();
    send_stream(0, "len_max");
    checks++;
    if (wr_data.size() != 4096) $display("FAIL len_max write_count got %0d required 4096", wr_data.size());
    else passes++;
    bad = 0;
    for (int k = 0; k < wr_data.size() && k < exp_data.size(); k++)
      if (wr_addr[k] !== 12'(k) || wr_data[k] !== exp_data[k]) bad++;
    checks++;
    if (bad != 0) $display("FAIL len_max bad_writes got %0d required 0", bad);
    else passes++;
    checks++;
    if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== 12'hFFF)
      $display("FAIL len_max last_addr got %h required fff",
               (wr_addr.size() == 0) ? 12'h000 : wr_addr[wr_addr.size()-1]);
    else passes++;
    checks++;
    if ({done, error, core_rst} !== 3'b101) $display("FAIL len_max done/error/core_rst=%b required 101", {done, error, core_rst});
    else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    stim.delete();
    words.delete();
    for (int w = 0; w < 8; w++) words.push_back($urandom | 32'h0101_0101);
    push_frame(32'd8, 8'h00);
    while (stim.size() > 1 + 4 + 5*4 + 2) void'(stim.pop_back());
    send_stream(0, "reset_mid");
    checks++;
    if (wr_data.size() != 5) $display("FAIL reset_mid pre_writes got %0d required 5", wr_data.size());
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_rst, done, error} !== '0)
      $display("FAIL reset_mid outputs rdy=%b we=%b addr=%h wdata=%h core_rst=%b done=%b error=%b required all 0",
               bus.rx_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, core_rst, done, error);
    else passes++;
    do_reset();
    stim.delete();
    words.delete();
    words.push_back(32'h0000_0013);
    words.push_back(32'h0010_0093);
    push_frame(32'd2, 8'h00);
    model_frame();
    send_stream(0, "reset_mid_reload");
    checks++;
    if (wr_data.size() != 2 || wr_addr[0] !== 12'h000 || wr_data[0] !== 32'h0000_0013 ||
        wr_addr[1] !== 12'h001 || wr_data[1] !== 32'h0010_0093)
      $display("FAIL reset_mid_reload writes n=%0d required 2 writes 0:00000013 1:00100093", wr_data.size());
    else passes++;
    checks++;
    if ({done, error, core_rst} !== 3'b101) $display("FAIL reset_mid_reload done/error/core_rst=%b required 101", {done, error, core_rst});
    else passes++;
  endtask

  initial begin
    test_reset();
    test_frame_table();
    test_random_gaps();
    test_len_max();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
